// File: rtl/regfile_pkg.sv
// Shared types and constants for the warp register file: clear-sequencer states
// and special-register offsets counted back from NUM_REGS.
package regfile_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

  localparam int unsigned SR_BLOCK = 3;
  localparam int unsigned SR_TPB   = 2;
  localparam int unsigned SR_TID   = 1;

endpackage

// File: rtl/regfile_lane.sv
// One lane's general-purpose register storage: two combinational read ports,
// one write port and a clear port that zeroes one row per cycle.
module regfile_lane
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_GP = 13,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic [DATA_W-1:0] o_rd_data1_c,
  output logic [DATA_W-1:0] o_rd_data2_c
);

  localparam logic [ADDR_W-1:0] GP_END = ADDR_W'(NUM_GP);

  logic [DATA_W-1:0] r_mem [NUM_GP];

  // Clear has priority; the top level never issues both in one cycle anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_GP); k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_clr_en) begin
      r_mem[i_clr_addr] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data1_c = (i_rd_addr1 < GP_END) ? r_mem[i_rd_addr1] : '0;
  assign o_rd_data2_c = (i_rd_addr2 < GP_END) ? r_mem[i_rd_addr2] : '0;

endmodule

// File: rtl/warp_regfile.sv
// Multi-lane warp register file with special registers and a clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-edge write data into read results.
module warp_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned NUM_REGS  = 16,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS),
  localparam int unsigned NUM_GP   = NUM_REGS - 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr1,
  input  logic [ADDR_W-1:0]             rd_addr2,
  output logic                          rd_valid,
  output logic [NUM_LANES*DATA_W-1:0]   rd_data1,
  output logic [NUM_LANES*DATA_W-1:0]   rd_data2,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [NUM_LANES-1:0]          wr_mask,
  input  logic [NUM_LANES*DATA_W-1:0]   wr_data,
  input  logic [DATA_W-1:0]             block_id,
  input  logic [DATA_W-1:0]             threads_per_block,
  input  logic [DATA_W-1:0]             thread_base,
  input  logic                          clr_req,
  output logic                          clr_busy,
  output logic                          clr_done
);

  localparam int unsigned       BUS_W   = NUM_LANES * DATA_W;
  localparam logic [ADDR_W-1:0] GP_END  = ADDR_W'(NUM_GP);
  localparam logic [ADDR_W-1:0] GP_LAST = ADDR_W'(NUM_GP - 1);
  localparam logic [ADDR_W-1:0] A_BLOCK = ADDR_W'(NUM_REGS - SR_BLOCK);
  localparam logic [ADDR_W-1:0] A_TPB   = ADDR_W'(NUM_REGS - SR_TPB);
  localparam logic [ADDR_W-1:0] A_TID   = ADDR_W'(NUM_REGS - SR_TID);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_clr_busy;
  logic              w_clr_busy_nxt;
  logic              r_clr_done;
  logic              w_clr_done_nxt;

  logic              w_clr_en;
  logic              w_wr_accept;
  logic              w_rd_accept;
  logic [BUS_W-1:0]  w_rd_nxt1;
  logic [BUS_W-1:0]  w_rd_nxt2;

  logic              r_rd_valid;
  logic [BUS_W-1:0]  r_rd_data1;
  logic [BUS_W-1:0]  r_rd_data2;

  // Clear sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CLR_IDLE;
      r_ptr      <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_clr_busy <= w_clr_busy_nxt;
      r_clr_done <= w_clr_done_nxt;
    end
  end

  // Next state; busy/done are computed for the state being entered.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_clr_busy_nxt = 1'b0;
    w_clr_done_nxt = 1'b0;
    case (r_state)
      CLR_IDLE: begin
        if (clr_req) begin
          w_state_nxt    = CLR_RUN;
          w_ptr_nxt      = '0;
          w_clr_busy_nxt = 1'b1;
        end
      end
      CLR_RUN: begin
        w_clr_busy_nxt = 1'b1;
        if (r_ptr == GP_LAST) begin
          w_state_nxt    = CLR_DONE;
          w_ptr_nxt      = '0;
          w_clr_done_nxt = 1'b1;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
      CLR_DONE: begin
        w_state_nxt = CLR_IDLE;
      end
      default: begin
        w_state_nxt = CLR_IDLE;
      end
    endcase
  end

  assign w_clr_en    = (r_state == CLR_RUN);
  assign w_wr_accept = wr_en && !r_clr_busy && (wr_addr < GP_END);
  assign w_rd_accept = rd_en && !r_clr_busy;

  function automatic logic [DATA_W-1:0] f_read(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic [DATA_W-1:0] blk,
    input logic [DATA_W-1:0] tpb,
    input logic [DATA_W-1:0] tid
  );
    if (a < GP_END)        return stored;
    else if (a == A_BLOCK) return blk;
    else if (a == A_TPB)   return tpb;
    else if (a == A_TID)   return tid;
    else                   return '0;
  endfunction

  for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic [DATA_W-1:0] w_tid;
    logic              w_byp1;
    logic              w_byp2;

    regfile_lane #(
      .DATA_W (DATA_W),
      .NUM_GP (NUM_GP),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .i_wr_en      (w_wr_accept && wr_mask[g]),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data[g*DATA_W +: DATA_W]),
      .i_clr_en     (w_clr_en),
      .i_clr_addr   (r_ptr),
      .i_rd_addr1   (rd_addr1),
      .i_rd_addr2   (rd_addr2),
      .o_rd_data1_c (w_rd1),
      .o_rd_data2_c (w_rd2)
    );

`ifdef REGFILE_BYPASS_EN
    assign w_byp1 = w_wr_accept && wr_mask[g] && (wr_addr == rd_addr1);
    assign w_byp2 = w_wr_accept && wr_mask[g] && (wr_addr == rd_addr2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign w_tid  = thread_base + DATA_W'(g);
    assign w_src1 = w_byp1 ? wr_data[g*DATA_W +: DATA_W] : w_rd1;
    assign w_src2 = w_byp2 ? wr_data[g*DATA_W +: DATA_W] : w_rd2;

    assign w_rd_nxt1[g*DATA_W +: DATA_W] = f_read(rd_addr1, w_src1, block_id, threads_per_block, w_tid);
    assign w_rd_nxt2[g*DATA_W +: DATA_W] = f_read(rd_addr2, w_src2, block_id, threads_per_block, w_tid);
  end

  // Read result registers hold until the next accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data1 <= '0;
      r_rd_data2 <= '0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_data1 <= w_rd_nxt1;
        r_rd_data2 <= w_rd_nxt2;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data1 = r_rd_data1;
  assign rd_data2 = r_rd_data2;
  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;

endmodule

// File: tb/tb_warp_regfile.sv
// Self-checking bench for warp_regfile: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_warp_regfile;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned NUM_GP    = NUM_REGS - 3;
  localparam int unsigned BUS_W     = NUM_LANES * DATA_W;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hAAAA_AAAA;
`else
  localparam logic [31:0] BYP_EXP = 32'h5555_5555;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr1 = '0;
  logic [ADDR_W-1:0] rd_addr2 = '0;
  logic              rd_valid;
  logic [BUS_W-1:0]  rd_data1;
  logic [BUS_W-1:0]  rd_data2;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [NUM_LANES-1:0] wr_mask = '0;
  logic [BUS_W-1:0]  wr_data = '0;
  logic [DATA_W-1:0] block_id = '0;
  logic [DATA_W-1:0] threads_per_block = '0;
  logic [DATA_W-1:0] thread_base = '0;
  logic              clr_req = 1'b0;
  logic              clr_busy;
  logic              clr_done;

  int n_chk = 0;
  int n_err = 0;

  warp_regfile #(
    .DATA_W    (DATA_W),
    .NUM_LANES (NUM_LANES),
    .NUM_REGS  (NUM_REGS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rd_en             (rd_en),
    .rd_addr1          (rd_addr1),
    .rd_addr2          (rd_addr2),
    .rd_valid          (rd_valid),
    .rd_data1          (rd_data1),
    .rd_data2          (rd_data2),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_mask           (wr_mask),
    .wr_data           (wr_data),
    .block_id          (block_id),
    .threads_per_block (threads_per_block),
    .thread_base       (thread_base),
    .clr_req           (clr_req),
    .clr_busy          (clr_busy),
    .clr_done          (clr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents plus a busy countdown.
  logic [DATA_W-1:0] m_mem [NUM_LANES][NUM_GP];
  int                m_clr_cnt = 0;
  logic [BUS_W-1:0]  exp_d1 = '0;
  logic [BUS_W-1:0]  exp_d2 = '0;
  logic              exp_valid = 1'b0;
  logic              exp_busy = 1'b0;
  logic              exp_done = 1'b0;
  logic              m_busy_now;
  logic              m_wr_ok;

  function automatic logic [DATA_W-1:0] m_val(input int lane, input int a);
    if (a < int'(NUM_GP))             return m_mem[lane][a];
    else if (a == int'(NUM_REGS) - 3) return block_id;
    else if (a == int'(NUM_REGS) - 2) return threads_per_block;
    else if (a == int'(NUM_REGS) - 1) return DATA_W'(int'(thread_base) + lane);
    else                              return '0;
  endfunction

  function automatic logic [DATA_W-1:0] m_port(input int lane, input int a);
    logic [DATA_W-1:0] v;
    v = m_val(lane, a);
`ifdef REGFILE_BYPASS_EN
    if (m_wr_ok && int'(wr_addr) == a && wr_mask[lane]) v = wr_data[lane*DATA_W +: DATA_W];
`endif
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < int'(NUM_LANES); l++)
        for (int r = 0; r < int'(NUM_GP); r++) m_mem[l][r] = '0;
      m_clr_cnt = 0;
      exp_d1 = '0; exp_d2 = '0;
      exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      m_busy_now = (m_clr_cnt != 0);
      m_wr_ok    = wr_en && !m_busy_now && (int'(wr_addr) < int'(NUM_GP));
      exp_valid  = rd_en && !m_busy_now;
      if (exp_valid) begin
        for (int l = 0; l < int'(NUM_LANES); l++) begin
          exp_d1[l*DATA_W +: DATA_W] = m_port(l, int'(rd_addr1));
          exp_d2[l*DATA_W +: DATA_W] = m_port(l, int'(rd_addr2));
        end
      end
      if (m_wr_ok)
        for (int l = 0; l < int'(NUM_LANES); l++)
          if (wr_mask[l]) m_mem[l][int'(wr_addr)] = wr_data[l*DATA_W +: DATA_W];
      if (m_busy_now) begin
        m_clr_cnt = m_clr_cnt - 1;
      end else if (clr_req) begin
        // Nothing can observe rows mid-clear, so the model zeroes them all at once.
        m_clr_cnt = int'(NUM_GP) + 1;
        for (int l = 0; l < int'(NUM_LANES); l++)
          for (int r = 0; r < int'(NUM_GP); r++) m_mem[l][r] = '0;
      end
      exp_busy = (m_clr_cnt != 0);
      exp_done = (m_clr_cnt == 1);
    end
  end

  always @(negedge clk) begin
    chk("rd_valid", 64'(rd_valid), 64'(exp_valid));
    chk("rd_data1", 64'(rd_data1), 64'(exp_d1));
    chk("rd_data2", 64'(rd_data2), 64'(exp_d2));
    chk("clr_busy", 64'(clr_busy), 64'(exp_busy));
    chk("clr_done", 64'(clr_done), 64'(exp_done));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [NUM_LANES-1:0] m,
                          input logic [BUS_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    rd_en = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic run_clear(output int n_busy, output int done_at);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    n_busy  = 0;
    done_at = -1;
    while (clr_busy && n_busy < 40) begin
      n_busy++;
      if (clr_done) done_at = n_busy;
      rd_en = 1'b1; rd_addr1 = '0; rd_addr2 = 4'd1;
      wr_en = 1'b1; wr_addr = '0; wr_mask = '1; wr_data = '1;
      clr_req = 1'b1;
      cyc();
    end
    rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
  endtask

  int n_busy;
  int done_at;

  initial begin
    repeat (3) cyc();
    chk("reset_busy", 64'(clr_busy), 64'd0);
    chk("reset_data1", 64'(rd_data1), 64'd0);
    reset = 1'b0;
    cyc();

    do_read(4'd0, 4'd5);
    chk("r0r5_valid", 64'(rd_valid), 64'd1);
    chk("r0r5_data", 64'({rd_data1, rd_data2}), 64'd0);
    cyc();
    chk("valid_pulse", 64'(rd_valid), 64'd0);

    do_write(4'd3, 4'b0101, 32'h4433_2211);
    do_read(4'd3, 4'd3);
    chk("masked_write", 64'(rd_data1), 64'h0033_0011);
    chk("model_masked", 64'(exp_d1), 64'h0033_0011);

    block_id = 8'd7; threads_per_block = 8'd32; thread_base = 8'hFE;
    do_write(4'd13, 4'hF, 32'hDEAD_BEEF);
    do_read(4'd13, 4'd15);
    chk("sr_block", 64'(rd_data1), 64'h0707_0707);
    chk("sr_tid_wrap", 64'(rd_data2), 64'h0100_FFFE);
    chk("model_tid", 64'(exp_d2), 64'h0100_FFFE);
    do_read(4'd14, 4'd14);
    chk("sr_tpb", 64'(rd_data1), 64'h2020_2020);

    do_write(4'd2, 4'hF, 32'h5555_5555);
    wr_en = 1'b1; wr_addr = 4'd2; wr_mask = 4'hF; wr_data = 32'hAAAA_AAAA;
    rd_en = 1'b1; rd_addr1 = 4'd2; rd_addr2 = 4'd2;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("same_edge", 64'(rd_data1), 64'(BYP_EXP));
    chk("model_same_edge", 64'(exp_d1), 64'(BYP_EXP));
    do_read(4'd2, 4'd2);
    chk("after_write", 64'(rd_data1), 64'hAAAA_AAAA);

    for (int r = 0; r < int'(NUM_GP); r++)
      do_write(ADDR_W'(r), 4'hF, {4{DATA_W'(r + 8'h31)}});
    do_read(4'd12, 4'd0);
    chk("fill_r12", 64'(rd_data1), 64'h3D3D_3D3D);
    run_clear(n_busy, done_at);
    chk("clear_len", 64'(n_busy), 64'(NUM_GP + 1));
    chk("clear_done_at", 64'(done_at), 64'(NUM_GP + 1));
    chk("held_data", 64'(rd_data1), 64'h3D3D_3D3D);
    for (int r = 0; r < int'(NUM_GP); r++) begin
      do_read(ADDR_W'(r), ADDR_W'(r));
      chk("cleared", 64'(rd_data1), 64'd0);
    end

    do_write(4'd4, 4'hF, 32'h1234_5678);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (4) cyc();
    #2 reset = 1'b1;
    #1 chk("abort_busy", 64'(clr_busy), 64'd0);
    chk("abort_done", 64'(clr_done), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    run_clear(n_busy, done_at);
    chk("reclear_len", 64'(n_busy), 64'(NUM_GP + 1));
    chk("reclear_done_at", 64'(done_at), 64'(NUM_GP + 1));

    for (int i = 0; i < 600; i++) begin
      rd_en    = ($urandom_range(3) != 0);
      rd_addr1 = ADDR_W'($urandom_range(NUM_REGS - 1));
      rd_addr2 = ADDR_W'($urandom_range(NUM_REGS - 1));
      wr_en    = ($urandom_range(1) != 0);
      wr_addr  = ($urandom_range(3) == 0) ? rd_addr1 : ADDR_W'($urandom_range(NUM_REGS - 1));
      wr_mask  = NUM_LANES'($urandom);
      wr_data  = BUS_W'($urandom);
      clr_req  = ($urandom_range(40) == 0);
      if ($urandom_range(15) == 0) begin
        block_id          = DATA_W'($urandom);
        threads_per_block = DATA_W'($urandom);
        thread_base       = DATA_W'($urandom);
      end
      cyc();
    end
    rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/warp_regfile.md
# warp_regfile

Parametrised multi-lane register file serving one warp of SIMD threads: each lane owns a private bank of general-purpose registers plus three read-only special registers (block ID, threads per block, per-lane thread ID). Two synchronous read ports return all lanes in parallel with one-cycle latency. Writes are lane-masked. A built-in clear sequencer zeroes every general-purpose register between kernel launches without a global reset. Sits between the core's decode/issue stage and its ALU/LSU lanes.

## Interface
- DATA_W, 8, register width in bits
- NUM_LANES, 4, threads (lanes) per warp
- NUM_REGS, 16, architectural registers per lane, including 3 read-only; must be ≥ 4
- ADDR_W, $clog2(NUM_REGS), derived; do not override
- NUM_GP, NUM_REGS-3, derived; count of writable registers R0..R(NUM_GP-1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rd_en  in  1  read request, samples both read addresses
- rd_addr1  in  ADDR_W  read port 1 register index
- rd_addr2  in  ADDR_W  read port 2 register index
- rd_valid  out  1  one-cycle pulse: rd_data1/2 updated
- rd_data1  out  NUM_LANES*DATA_W  port 1 data, lane i at bits [i*DATA_W +: DATA_W]
- rd_data2  out  NUM_LANES*DATA_W  port 2 data, same packing
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write register index
- wr_mask  in  NUM_LANES  per-lane write enable
- wr_data  in  NUM_LANES*DATA_W  write data, same packing
- block_id  in  DATA_W  value of R(NUM_REGS-3)
- threads_per_block  in  DATA_W  value of R(NUM_REGS-2)
- thread_base  in  DATA_W  lane i reads R(NUM_REGS-1) as thread_base+i, mod 2^DATA_W
- clr_req  in  1  start clear sequence
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse at clear completion

## Operation
- Write: wr_en=1 with wr_addr < NUM_GP and clr_busy=0 → every lane i with wr_mask[i]=1 stores its data slice at the clock edge. Writes to wr_addr ≥ NUM_GP are silently dropped.
- Read: rd_en=1 with clr_busy=0 registers both ports for all lanes. Special indices return the live input values sampled at that edge.
- Reads with rd_en=1 while clr_busy=1 are dropped: rd_valid stays 0 and data holds.
- rd_data holds its last value until the next accepted read.
- Clear FSM states:
  - IDLE: on clr_req=1, go to CLEAR with ptr=0.
  - CLEAR: zero row ptr in all lanes each cycle; ptr increments; after ptr=NUM_GP-1, go to DONE.
  - DONE: 1 cycle, then IDLE.
- clr_req in CLEAR or DONE is ignored. wr_en during CLEAR or DONE is ignored.
- Reset: all GP registers = 0, FSM = IDLE, ptr = 0. Reset in mid-clear aborts the sequence; no clr_done is emitted.

## Timing
- Reset values: rd_data1 = rd_data2 = 0, rd_valid = 0, clr_busy = 0, clr_done = 0.
- Read latency: rd_en at edge N → data and rd_valid=1 visible after edge N (valid through cycle N+1). Back-to-back reads are allowed every cycle.
- Write visibility: a write at edge N is seen by a read at edge N+1 or later. Same-edge read/write behaviour is set by the Configuration macro.
- Clear timing: clr_req sampled at edge N.
  - clr_busy=1 for NUM_GP cycles, starting after edge N.
  - Then DONE for 1 cycle with clr_busy=1 and clr_done=1.
  - clr_busy=0 from the following cycle.
  - Total busy = NUM_GP+1 cycles.
- clr_busy and clr_done are registered outputs derived from FSM state.

## Configuration
- REGFILE_BYPASS_EN defined: a read and an accepted write at the same edge, same address, forward the new write data into rd_data for lanes with wr_mask=1. Unmasked lanes return stored data.
- REGFILE_BYPASS_EN undefined: a same-edge read returns the pre-write (old) value in all lanes.

## Structure
- Package regfile_pkg holds:
  - clear FSM enum (CLR_IDLE, CLR_RUN, CLR_DONE)
  - localparam offsets for special registers (SR_BLOCK=3, SR_TPB=2, SR_TID=1, counted back from NUM_REGS)
- Sub-module regfile_lane: one lane's NUM_GP×DATA_W storage with 2 read and 1 write port, plus clear write. Instantiate NUM_LANES times in a generate loop. FSM and special-register muxing live in the top level.

## Test plan
- Reset, then read R0/R5 → rd_valid pulse one cycle after rd_en; all lanes 0. All outputs 0 during reset.
- DATA_W=8, NUM_LANES=4: write R3 with mask 4'b0101, data {8'h44,8'h33,8'h22,8'h11}. Read R3 → lanes {0,8'h33,0,8'h11}. Write R13 (index ≥ NUM_GP) → read R13 returns block_id, unchanged.
- block_id=7, threads_per_block=32, thread_base=8'hFE: read R13/R15 → port 1 all lanes 7; port 2 lanes {8'h01,8'h00,8'hFF,8'hFE} (wrap-around).
- Fill R0..R12 with nonzero values, pulse clr_req → clr_busy for 14 cycles, clr_done on the last. Reads and writes during busy are dropped. Afterwards all GP registers read 0.
- Same-edge write R2=8'hAA, mask all, plus read R2 (old 8'h55) → returns 8'hAA with REGFILE_BYPASS_EN, 8'h55 without.
- Assert reset at cycle 5 of a clear → clr_busy drops immediately, no clr_done; next clr_req runs a full 14-cycle sequence.
